adc_scan_sequencer: RTL and testbench

- Sequences the 12-bit SAR ADC FSM across up to NCH analog-mux channels.
- Per channel:
  - drives the mux select and waits for settling;
  - generates the st_conv sample pulse (high = sample, falling edge = convert);
  - waits for adc_done and captures the 12-bit result.
- Delivers results on a valid/ready stream tagged with the channel number.
- Sits between system control logic and adc_fsm_12b_12s_v0 plus the analog input mux.

---
 rtl/adc_scan_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// ----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Purpose:
//    Scans the analog input mux of a 12-bit SAR ADC across the channels
//    selected in ch_mask. For each channel it drives mux_sel, waits for the
//    mux to settle, pulses st_conv (high = sample, falling edge = convert),
//    waits for adc_done and returns the result on a valid/ready stream
//    tagged with the channel number.
//
// Optional feature (macro ADC_SEQ_AVG_EN):
//    When defined, each channel is converted 2**AVG_LOG2 times back-to-back
//    after a single settle period. res_data is then the truncated mean of
//    those conversions. A timeout on any repeat discards the whole channel.
//    When undefined, one conversion is made per channel and AVG_LOG2 is unused.
//
// Ports:
//    clkin        in   sequencer clock
//    rst          in   asynchronous, active-high reset
//    enable       in   scan while high
//    single       in   1 = one pass over ch_mask then stop, 0 = continuous
//    ch_mask      in   [NCH]  channels included in the scan
//    mux_sel      out  [CH_W] analog mux select
//    st_conv      out  ADC sample/convert strobe
//    adc_done     in   ADC conversion done (asynchronous to clkin)
//    adc_result   in   [DW]   ADC conversion result
//    res_valid    out  result available
//    res_ready    in   consumer accepts result
//    res_ch       out  [CH_W] channel of res_data
//    res_data     out  [DW]   conversion result
//    busy         out  sequencer not idle
//    scan_done    out  one-cycle pulse at the end of a single-mode pass
//    timeout_err  out  sticky adc_done timeout flag
// ----------------------------------------------------------------------------
module adc_scan_sequencer #(
   parameter int NCH         = 4,
   parameter int CH_W        = 2,
   parameter int DW          = 12,
   parameter int SETTLE_CYC  = 2,
   parameter int SAMPLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 64,
   parameter int AVG_LOG2    = 2
) (
   input  logic            clkin,
   input  logic            rst,
   input  logic            enable,
   input  logic            single,
   input  logic [NCH-1:0]  ch_mask,
   output logic [CH_W-1:0] mux_sel,
   output logic            st_conv,
   input  logic            adc_done,
   input  logic [DW-1:0]   adc_result,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [CH_W-1:0] res_ch,
   output logic [DW-1:0]   res_data,
   output logic            busy,
   output logic            scan_done,
   output logic            timeout_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETTLE = 3'd1;
   localparam logic [2:0] SAMPLE = 3'd2;
   localparam logic [2:0] CONV   = 3'd3;
   localparam logic [2:0] OUT    = 3'd4;

   // One shared cycle counter serves settle, sample and timeout phases.
   localparam int CNT_MAX = (TIMEOUT_CYC > SAMPLE_CYC)
                          ? ((TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC)
                          : ((SAMPLE_CYC > SETTLE_CYC)  ? SAMPLE_CYC  : SETTLE_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   if (NCH < 2 || NCH > 16 || CH_W != $clog2(NCH) || SETTLE_CYC < 1 ||
       SAMPLE_CYC < 1 || TIMEOUT_CYC < 1 || AVG_LOG2 < 0) begin : g_bad_param
      $error("adc_scan_sequencer: illegal parameter set");
   end

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             enable_d;
   logic             pass_done;   // single pass finished; rearmed by enable low or single low
   logic [2:0]       done_sync;   // [1:0] synchroniser, [2] edge history
   logic             done_evt;

   logic             above_found;
   logic [CH_W-1:0]  above_ch;
   logic             low_found;
   logic [CH_W-1:0]  low_ch;
   logic             adv_has_next;
   logic [CH_W-1:0]  adv_ch;
   logic             conv_timeout;
   logic             advance;
   logic             sample_abort;

`ifdef ADC_SEQ_AVG_EN
   localparam int ACC_W = DW + AVG_LOG2;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2-1:0] rep;

   assign acc_sum      = acc + ACC_W'(adc_result);
   // Once the first conversion of a channel has been sampled, the channel is
   // committed and later repeats run to completion even if enable drops.
   assign sample_abort = !enable && (rep == '0);
`else
   assign sample_abort = !enable;
`endif

   // adc_done crosses from the ADC clock domain: two flops, then a rising-edge detect.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) done_sync <= '0;
      else     done_sync <= {done_sync[1:0], adc_done};
   end
   assign done_evt = done_sync[1] & ~done_sync[2];

   // Channel search over ch_mask relative to the current channel (mux_sel).
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      above_found = 1'b0;
      above_ch    = '0;
      low_found   = 1'b0;
      low_ch      = '0;
      // Descending scan: the last hit written is the lowest qualifying index.
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            low_found = 1'b1;
            low_ch    = CH_W'(i);
            if (i > int'(mux_sel)) begin
               above_found = 1'b1;
               above_ch    = CH_W'(i);
            end
         end
      end
   end

   // Next channel: the next set bit above the current one, wrapping only in continuous mode.
   assign adv_has_next = above_found | (~single & low_found);
   assign adv_ch       = above_found ? above_ch : low_ch;

   assign conv_timeout = (state == CONV) && !done_evt && (cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign advance      = conv_timeout || ((state == OUT) && res_ready);
   assign busy         = (state != IDLE);

   // NOTE: all sequential state uses non-blocking assignments; later assignments
   // in this block deliberately override earlier ones within the same cycle.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         enable_d    <= 1'b0;
         pass_done   <= 1'b0;
         mux_sel     <= '0;
         st_conv     <= 1'b0;
         res_valid   <= 1'b0;
         res_ch      <= '0;
         res_data    <= '0;
         scan_done   <= 1'b0;
         timeout_err <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
         acc         <= '0;
         rep         <= '0;
`endif
      end else begin
         enable_d  <= enable;
         scan_done <= 1'b0;
         if (!enable || !single) pass_done   <= 1'b0;
         if (enable && !enable_d) timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               if (enable && !pass_done && low_found) begin
                  // Continuous mode resumes after the last channel served.
                  mux_sel <= single ? low_ch : adv_ch;
                  cnt     <= '0;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                  cnt     <= '0;
                  st_conv <= 1'b1;
                  state   <= SAMPLE;
`ifdef ADC_SEQ_AVG_EN
                  acc     <= '0;
                  rep     <= '0;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SAMPLE: begin
               if (sample_abort) begin
                  st_conv <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                  st_conv <= 1'b0;
                  cnt     <= '0;
                  state   <= CONV;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            CONV: begin
               if (done_evt) begin
`ifdef ADC_SEQ_AVG_EN
                  if (rep == '1) begin
                     res_data  <= acc_sum[ACC_W-1:AVG_LOG2];
                     res_ch    <= mux_sel;
                     res_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     acc     <= acc_sum;
                     rep     <= rep + AVG_LOG2'(1);
                     cnt     <= '0;
                     st_conv <= 1'b1;
                     state   <= SAMPLE;
                  end
`else
                  res_data  <= adc_result;
                  res_ch    <= mux_sel;
                  res_valid <= 1'b1;
                  state     <= OUT;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            OUT: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         // Leaving a channel, either after the result handshake or on timeout.
         if (advance) begin
            if (conv_timeout) timeout_err <= 1'b1;
            cnt <= '0;
            if (!enable) begin
               state <= IDLE;
            end else if (adv_has_next) begin
               mux_sel <= adv_ch;
               state   <= SETTLE;
            end else begin
               state <= IDLE;
               if (single) begin
                  scan_done <= 1'b1;
                  pass_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Self-checking bench for adc_scan_sequencer. A behavioural ADC returns
// analog[ch] + k for the k-th back-to-back conversion of a channel. Expected
// results are computed from the channel mask and mode and queued; a monitor
// pops and compares on every res_valid/res_ready handshake.
// Honours ADC_SEQ_AVG_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

   localparam int NCH         = 4;
   localparam int CH_W        = 2;
   localparam int DW          = 12;
   localparam int SETTLE_CYC  = 2;
   localparam int SAMPLE_CYC  = 4;
   localparam int TIMEOUT_CYC = 64;
   localparam int AVG_LOG2    = 2;
`ifdef ADC_SEQ_AVG_EN
   localparam int NREP = 1 << AVG_LOG2;
`else
   localparam int NREP = 1;
`endif

   logic            clkin;
   logic            rst;
   logic            enable;
   logic            single;
   logic [NCH-1:0]  ch_mask;
   logic [CH_W-1:0] mux_sel;
   logic            st_conv;
   logic            adc_done;
   logic [DW-1:0]   adc_result;
   logic            res_valid;
   logic            res_ready;
   logic [CH_W-1:0] res_ch;
   logic [DW-1:0]   res_data;
   logic            busy;
   logic            scan_done;
   logic            timeout_err;

   adc_scan_sequencer #(
      .NCH(NCH), .CH_W(CH_W), .DW(DW), .SETTLE_CYC(SETTLE_CYC),
      .SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .AVG_LOG2(AVG_LOG2)
   ) dut (
      .clkin(clkin), .rst(rst), .enable(enable), .single(single), .ch_mask(ch_mask),
      .mux_sel(mux_sel), .st_conv(st_conv), .adc_done(adc_done), .adc_result(adc_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data),
      .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   // ---------------------------------------------------------------- checking
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // ---------------------------------------------------------- reference model
   typedef struct { int ch; int data; } exp_t;
   exp_t exp_q[$];
   int   analog [NCH];
   bit   hang_ch [NCH];

   // Truncated mean of the NREP conversions the ADC model returns for ch.
   function automatic int ref_data(input int ch);
      int sum = 0;
      for (int k = 0; k < NREP; k++) sum += analog[ch] + k;
      return sum / NREP;
   endfunction

   function automatic int next_wrap(input logic [NCH-1:0] m, input int last);
      for (int i = 1; i <= NCH; i++)
         if (m[(last + i) % NCH]) return (last + i) % NCH;
      return -1;
   endfunction

   task automatic push_ch(input int ch);
      exp_t e;
      e.ch   = ch;
      e.data = ref_data(ch);
      exp_q.push_back(e);
   endtask

   task automatic push_pass(input logic [NCH-1:0] m);
      for (int c = 0; c < NCH; c++) if (m[c]) push_ch(c);
   endtask

   // --------------------------------------------------------------- ADC model
   int prev_ch = -1;
   int rep_i   = 0;
   initial begin
      int ch;
      int d;
      adc_done   = 1'b0;
      adc_result = '0;
      forever begin
         @(posedge st_conv);
         adc_done = 1'b0;
         ch       = int'(mux_sel);
         rep_i    = (ch == prev_ch) ? (rep_i + 1) % NREP : 0;
         prev_ch  = ch;
         @(negedge st_conv);
         d = $urandom_range(1, 8);
         repeat (d) @(posedge clkin);
         #2;
         if (!hang_ch[ch]) begin
            adc_result = DW'(analog[ch] + rep_i);
            adc_done   = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- monitors
   int   n_rx          = 0;
   int   cyc           = 0;
   int   st_pulses     = 0;
   int   scan_done_cnt = 0;
   int   valid_rises   = 0;
   bit   chk_timing    = 0;
   bit   rand_ready    = 0;

   // Result scoreboard: pops one expected entry per handshake.
   always @(negedge clkin) begin
      exp_t e;
      if (!rst && res_valid && res_ready) begin
         n_rx++;
         check("sb_entry_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("res_ch", res_ch, e.ch);
            check("res_data", res_data, e.data);
         end
      end
   end

   // Strobe timing and event counters.
   always @(negedge clkin) begin
      logic [CH_W-1:0] prev_mux;
      logic            prev_busy;
      logic            prev_st;
      logic            prev_valid;
      int              last_mark;
      int              st_len;
      bit              first_pulse;
      cyc++;
      if (scan_done) scan_done_cnt++;
      if (res_valid && !prev_valid) valid_rises++;
      if ((mux_sel != prev_mux) || (busy && !prev_busy)) begin
         last_mark   = cyc;
         first_pulse = 1'b1;
      end
      if (st_conv && !prev_st) begin
         st_pulses++;
         st_len = 1;
         if (chk_timing && first_pulse) check("settle_cycles", cyc - last_mark, SETTLE_CYC);
         first_pulse = 1'b0;
      end else if (st_conv) begin
         st_len++;
      end
      if (!st_conv && prev_st && chk_timing) check("sample_cycles", st_len, SAMPLE_CYC);
      prev_mux   = mux_sel;
      prev_busy  = busy;
      prev_st    = st_conv;
      prev_valid = res_valid;
   end

   // Random consumer back-pressure.
   initial begin
      forever begin
         @(posedge clkin);
         #1;
         if (rand_ready) res_ready = 1'($urandom_range(0, 1));
      end
   end

   // ----------------------------------------------------------------- helpers
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      enable     = 1'b0;
      single     = 1'b0;
      ch_mask    = '0;
      res_ready  = 1'b0;
      rand_ready = 1'b0;
      chk_timing = 1'b0;
      tick(12);                 // let any stray ADC completion land first
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_q.delete();
      for (int c = 0; c < NCH; c++) hang_ch[c] = 1'b0;
      prev_ch       = -1;
      n_rx          = 0;
      st_pulses     = 0;
      scan_done_cnt = 0;
      valid_rises   = 0;
      tick(1);
   endtask

   task automatic wait_scan(input int target, input string name);
      for (int i = 0; i < 4000 && scan_done_cnt < target; i++) tick(1);
      check(name, scan_done_cnt, target);
   endtask

   task automatic wait_st(input logic lvl, input string name);
      for (int i = 0; i < 500 && st_conv !== lvl; i++) tick(1);
      check(name, st_conv, lvl);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 500 && res_valid !== 1'b1; i++) tick(1);
      check(name, res_valid, 1);
   endtask

   // -------------------------------------------------------------------- main
   initial begin
      int k;
      int hold_ok;
      int last;
      logic [NCH-1:0] m;

      rst = 1'b1;
      enable = 1'b0; single = 1'b0; ch_mask = '0; res_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin analog[c] = 0; hang_ch[c] = 1'b0; end

      // --- 1/2: single pass over 1011, sample/settle timing -----------------
      do_reset();
      check("reset_outputs",
            {mux_sel, st_conv, res_valid, res_ch, res_data, busy, scan_done, timeout_err}, 0);
      for (int c = 0; c < NCH; c++) analog[c] = 100 + c;
      chk_timing = 1'b1;
      single = 1'b1; ch_mask = 4'b1011; res_ready = 1'b1;
      push_pass(ch_mask);
      enable = 1'b1;
      wait_scan(1, "t1_scan_done");
      tick(20);
      check("t1_scan_done_once", scan_done_cnt, 1);
      check("t1_busy_after", busy, 0);
      check("t1_all_results", exp_q.size(), 0);
      check("t1_st_pulses", st_pulses, 3 * NREP);

      // --- 3: continuous 0110 with back-pressure, then wrap ----------------
      do_reset();
      for (int c = 0; c < NCH; c++) analog[c] = $urandom_range(0, 4000);
      single = 1'b0; ch_mask = 4'b0110; res_ready = 1'b0;
      last = 0;
      for (int i = 0; i < 3; i++) begin
         last = next_wrap(ch_mask, last);
         push_ch(last);
      end
      enable = 1'b1;
      wait_valid("t3_first_valid");
      k = st_pulses;
      hold_ok = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (res_valid === 1'b1 && res_ch === 2'd1 && res_data === DW'(ref_data(1)) &&
             st_conv === 1'b0)
            hold_ok++;
      end
      check("t3_hold_stable_cycles", hold_ok, 10);
      check("t3_no_new_st_conv", st_pulses - k, 0);
      res_ready = 1'b1;
      for (int i = 0; i < 2000 && n_rx < 3; i++) tick(1);
      enable = 1'b0;            // sequencer is now settling the next channel
      tick(30);
      check("t3_rx_count", n_rx, 3);
      check("t3_busy_after", busy, 0);

      // --- 4: timeout on channel 0, channel 2 still served ----------------
      do_reset();
      for (int c = 0; c < NCH; c++) analog[c] = $urandom_range(0, 4000);
      hang_ch[0] = 1'b1;
      single = 1'b1; ch_mask = 4'b0101; res_ready = 1'b1;
      push_ch(2);
      enable = 1'b1;
      wait_st(1'b1, "t4_st_high");
      wait_st(1'b0, "t4_st_low");
      k = 0;
      while (timeout_err !== 1'b1 && k < 200) begin
         tick(1);
         k++;
      end
      check("t4_timeout_cycles", k, TIMEOUT_CYC);
      check("t4_no_valid_on_timeout", res_valid, 0);
      wait_scan(1, "t4_scan_done");
      check("t4_results", exp_q.size(), 0);
      check("t4_valid_count", valid_rises, 1);
      check("t4_err_sticky", timeout_err, 1);
      ch_mask = '0;
      enable  = 1'b0;
      tick(3);
      check("t4_err_held_enable_low", timeout_err, 1);
      enable = 1'b1;
      tick(2);
      check("t4_err_cleared", timeout_err, 0);
      check("t4_idle", busy, 0);

      // --- 5a: enable dropped during SAMPLE --------------------------------
      do_reset();
      for (int c = 0; c < NCH; c++) analog[c] = $urandom_range(0, 4000);
      single = 1'b1; ch_mask = 4'b0001; res_ready = 1'b1;
      enable = 1'b1;
      wait_st(1'b1, "t5_st_high");
      enable = 1'b0;
      tick(1);
      check("t5_abort_st_conv", st_conv, 0);
      check("t5_abort_busy", busy, 0);
      tick(30);
      check("t5_no_result", valid_rises, 0);
      check("t5_no_scan_done", scan_done_cnt, 0);

      // --- 5b: reset while holding a result --------------------------------
      do_reset();
      single = 1'b1; ch_mask = 4'b0010; res_ready = 1'b0;
      enable = 1'b1;
      wait_valid("t5b_valid");
      #2;
      rst = 1'b1;
      #1;
      check("t5b_reset_outputs",
            {mux_sel, st_conv, res_valid, res_ch, res_data, busy, scan_done, timeout_err}, 0);
      enable = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(5);
      check("t5b_idle_after", busy, 0);

      // --- 6: averaging (NREP conversions per channel) ---------------------
      do_reset();
      analog[0] = 10;
      chk_timing = 1'b1;
      single = 1'b1; ch_mask = 4'b0001; res_ready = 1'b1;
      push_ch(0);
      enable = 1'b1;
      wait_scan(1, "t6_scan_done");
      check("t6_results", exp_q.size(), 0);
      check("t6_st_pulses", st_pulses, NREP);

      // --- 7: random single passes with random back-pressure ---------------
      do_reset();
      chk_timing = 1'b1;
      rand_ready = 1'b1;
      single = 1'b1;
      for (int it = 0; it < 6; it++) begin
         for (int c = 0; c < NCH; c++) analog[c] = $urandom_range(0, 4000);
         m = NCH'($urandom_range(1, (1 << NCH) - 1));
         ch_mask = m;
         push_pass(m);
         k = scan_done_cnt;
         enable = 1'b1;
         wait_scan(k + 1, "t7_scan_done");
         check("t7_results", exp_q.size(), 0);
         enable = 1'b0;
         tick(2);
      end
      rand_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
